fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V core. Holds the PC and issues in-order requests to instruction memory over a request/grant/response handshake. Buffers returned words in a small FIFO and hands them to decode with a valid/ready handshake. Consumes the execute-stage redirect (branch taken / jump target): flushes the buffer, discards in-flight responses and restarts fetch at the target.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM encodings, default reset PC and instruction width.
package fetch_unit_pkg;

    localparam int          ILEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer for fetched {pc, instr} words.
// Synchronous clear; push and pop may share a cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointers, count and storage contents.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != FULL) || do_pop);
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = nxt(wr_q);
            end
            if (do_pop) begin
                rd_d = nxt(rd_q);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests,
// response buffering and redirect with stale-response discard.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [ILEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            fetch_misaligned_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = ILEN + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;

    logic [CW-1:0]   fifo_cnt;
    logic [FW-1:0]   fifo_head;
    logic [CW:0]     used;
    logic            gnt_fire;
    logic            accept;
    logic            push;
    logic            pop;

    // Credits count both in-flight and buffered words.
    assign used       = {1'b0, out_q} + {1'b0, fifo_cnt};
    assign imem_req_o = (state_q == FETCH_RUN) &&
                        (used < (CW + 1)'(DEPTH));
    assign gnt_fire   = imem_req_o && imem_gnt_i;
    assign accept     = imem_rvalid_i && (disc_q == '0) &&
                        (state_q == FETCH_RUN);
    assign push       = accept && !redirect_i;
    assign pop        = if_valid_o && if_ready_i && !redirect_i;

    // Next state, PC and credit/discard bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        disc_d   = disc_q;
        out_d    = out_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
        if (imem_rvalid_i && (disc_q != '0)) begin
            disc_d = disc_q - 1'b1;
        end
        if (accept) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
        unique case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN: begin
                if (gnt_fire) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_BOOT;
        endcase
        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            rsp_pc_d = redirect_pc_i;
            disc_d   = out_d;
            state_d  = (redirect_pc_i[1:0] != 2'b00) ?
                       FETCH_HALT : FETCH_RUN;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect_i),
        .push_i  (push),
        .data_i  ({rsp_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign imem_addr_o        = pc_q;
    assign if_valid_o         = (fifo_cnt != '0) &&
                                (state_q != FETCH_HALT);
    assign if_instr_o         = fifo_head[ILEN-1:0];
    assign if_pc_o            = fifo_head[FW-1:ILEN];
    assign fetch_misaligned_o = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory/decode timing checked
// against a queue-based model of the fetch stream.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        fetch_misaligned_o;

    fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_gnt_i         (imem_gnt_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i),
        .if_valid_o         (if_valid_o),
        .if_ready_i         (if_ready_i),
        .if_instr_o         (if_instr_o),
        .if_pc_o            (if_pc_o),
        .fetch_misaligned_o (fetch_misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } word_t;

    pend_t       pend[$];
    word_t       fifo_q[$];
    logic [31:0] popped[$];
    logic [31:0] req_pc;
    bit          halted;
    bit          boot;
    int          cyc;
    int          errors = 0;
    int          checks = 0;
    int          gnt_pct = 100;
    int          rdy_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit model_req();
        return !boot && !halted &&
               (pend.size() + fifo_q.size() < DEPTH);
    endfunction

    function automatic logic [31:0] pget(input int i);
        return (popped.size() > i) ? popped[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if_ready_i    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pend.delete();
        fifo_q.delete();
        popped.delete();
        req_pc = 32'h0;
        halted = 1'b0;
        boot   = 1'b1;
        cyc    = 0;
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", if_valid_o, 0);
        chk("rst_mis", fetch_misaligned_o, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_instr", if_instr_o, 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
    endtask

    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit    exp_req;
        bit    rv;
        bit    gnt;
        bit    rdy;
        bit    pop;
        pend_t h;
        exp_req = model_req();
        chk("req", imem_req_o, exp_req);
        chk("addr", imem_addr_o, req_pc);
        chk("valid", if_valid_o, fifo_q.size() != 0);
        chk("misaligned", fetch_misaligned_o, halted);
        if (fifo_q.size() != 0) begin
            chk("head_pc", if_pc_o, fifo_q[0].pc);
            chk("head_instr", if_instr_o, fifo_q[0].ins);
        end
        rv  = (pend.size() != 0) && (pend[0].due <= cyc);
        gnt = exp_req && ($urandom_range(99) < gnt_pct);
        rdy = $urandom_range(99) < rdy_pct;
        pop = (fifo_q.size() != 0) && rdy && !redir;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? memfn(pend[0].addr) : $urandom;
        imem_gnt_i    = gnt;
        if_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        if (pop) begin
            popped.push_back(fifo_q[0].pc);
            void'(fifo_q.pop_front());
        end
        if (rv) begin
            h = pend.pop_front();
            if (!h.stale && !halted && !redir)
                fifo_q.push_back('{h.addr, memfn(h.addr)});
        end
        if (gnt) begin
            pend.push_back('{req_pc,
                cyc + $urandom_range(lat_hi, lat_lo), redir});
            req_pc = req_pc + 32'd4;
        end
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            fifo_q.delete();
            req_pc = tgt;
            halted = (tgt[1:0] != 2'b00);
        end
        boot = 1'b0;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    initial begin
        int          first_valid;
        bit          found;
        logic [31:0] hold_i;
        logic [31:0] hold_p;
        logic [31:0] tgt;

        // 4 fetches, 1-cycle latency, decode always ready
        do_reset();
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            if (if_valid_o && first_valid < 0) first_valid = i;
            cycle(1'b0, 32'h0);
        end
        chk("first_valid_cycle", first_valid, 3);
        chk("seq0", pget(0), 32'h0);
        chk("seq1", pget(1), 32'h4);
        chk("seq2", pget(2), 32'h8);
        chk("seq3", pget(3), 32'hC);

        // decode stall fills credits, then drains cleanly
        rdy_pct = 0;
        run(8);
        chk("stall_req", imem_req_o, 0);
        chk("stall_valid", if_valid_o, 1);
        hold_i = if_instr_o;
        hold_p = if_pc_o;
        run(3);
        chk("stall_hold_instr", if_instr_o, hold_i);
        chk("stall_hold_pc", if_pc_o, hold_p);
        popped.delete();
        rdy_pct = 100;
        run(10);
        chk("resume0", pget(0), hold_p);
        chk("resume1", pget(1), hold_p + 32'd4);
        chk("resume2", pget(2), hold_p + 32'd8);

        // redirect with two requests in flight
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++)
            cycle(1'b0, 32'h0);
        chk("two_inflight", pend.size(), 2);
        popped.delete();
        cycle(1'b1, 32'h100);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_valid", if_valid_o, 0);
        run(15);
        chk("redir_first_pc", pget(0), 32'h100);
        chk("redir_second_pc", pget(1), 32'h104);

        // redirect coinciding with rvalid and grant
        lat_lo = 1;
        lat_hi = 2;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend.size() != 0 && pend[0].due <= cyc &&
                model_req())
                found = 1'b1;
            else
                cycle(1'b0, 32'h0);
        end
        chk("coincide_found", found, 1);
        popped.delete();
        cycle(1'b1, 32'h180);
        run(12);
        chk("coincide_first_pc", pget(0), 32'h180);

        // misaligned target halts until the next redirect
        gnt_pct = 70;
        cycle(1'b1, 32'h102);
        chk("halt_mis", fetch_misaligned_o, 1);
        chk("halt_req", imem_req_o, 0);
        run(6);
        popped.delete();
        cycle(1'b1, 32'h200);
        chk("unhalt_mis", fetch_misaligned_o, 0);
        run(15);
        chk("unhalt_first_pc", pget(0), 32'h200);

        // PC wraps modulo 2^32
        popped.delete();
        cycle(1'b1, 32'hFFFF_FFF8);
        run(20);
        chk("wrap0", pget(0), 32'hFFFF_FFF8);
        chk("wrap1", pget(1), 32'hFFFF_FFFC);
        chk("wrap2", pget(2), 32'h0000_0000);

        // reset mid-stream restarts at RESET_PC
        run(3);
        do_reset();
        run(12);
        chk("rst_restart_pc", pget(0), 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                rdy_pct = $urandom_range(100, 10);
                lat_lo  = $urandom_range(2, 1);
                lat_hi  = lat_lo + $urandom_range(3, 0);
            end
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else if ($urandom_range(99) < 3) begin
                case ($urandom_range(9))
                    0:       tgt = 32'hFFFF_FFF8;
                    1:       tgt = ($urandom & 32'hFFFF_FFFC) |
                                   32'd2;
                    default: tgt = $urandom & 32'hFFFF_FFFC;
                endcase
                cycle(1'b1, tgt);
            end else begin
                cycle(1'b0, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
